// File: rtl/f8_fetch_pkg.sv
// Shared types and helpers for the f8 instruction prefetch path: bank address
// mapping, fetch-word byte ordering and the byte-count type.
package f8_fetch_pkg;

    localparam logic [15:0] F8_RESET_PC = 16'h4000;

    // Wide enough for any legal queue depth (4..16).
    typedef logic [4:0] byte_count_t;

    typedef struct packed {
        logic [14:0] even;
        logic [14:0] odd;
    } bank_addr_t;

    // An odd start address takes its second byte from the next even word.
    function automatic bank_addr_t bank_addr(input logic [15:0] a);
        bank_addr_t r;
        r.odd  = a[15:1];
        r.even = a[0] ? a[15:1] + 15'd1 : a[15:1];
        return r;
    endfunction

    // Returns the two fetched bytes with the byte at address a in [7:0].
    function automatic logic [15:0] bank_order(input logic [15:0] a,
                                               input logic [7:0]  d_even,
                                               input logic [7:0]  d_odd);
        return a[0] ? {d_even, d_odd} : {d_odd, d_even};
    endfunction

endpackage

// File: rtl/f8_byte_fifo.sv
// Circular byte queue: 2-byte push, 0..MAX_INST-byte pop, head peek window.
// Pointers wrap mod DEPTH so non-power-of-two depths are legal.
module f8_byte_fifo
    import f8_fetch_pkg::*;
#(
    parameter int unsigned DEPTH    = 6,
    parameter int unsigned MAX_INST = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clear,
    input  logic                           push,
    input  logic [15:0]                    push_data,
    input  logic [$clog2(MAX_INST+1)-1:0]  pop,
    output logic [8*MAX_INST-1:0]          peek,
    output byte_count_t                    count
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [7:0]    buf_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    byte_count_t   count_q, count_d;

    // p < DEPTH and inc <= DEPTH, so a single conditional subtract suffices.
    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input int unsigned inc);
        int unsigned s;
        s = 32'(p) + inc;
        if (s >= DEPTH) begin
            s = s - DEPTH;
        end
        return PW'(s);
    endfunction

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clear) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = ptr_add(head_q, 32'(pop));
            if (push) begin
                tail_d = ptr_add(tail_q, 2);
            end
            count_d = count_q - byte_count_t'(pop) + (push ? byte_count_t'(2) : byte_count_t'(0));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear && !reset) begin
            buf_q[tail_q]             <= push_data[7:0];
            buf_q[ptr_add(tail_q, 1)] <= push_data[15:8];
        end
    end

    always_comb begin
        for (int i = 0; i < int'(MAX_INST); i++) begin
            if (int'(count_q) > i) begin
                peek[8*i +: 8] = buf_q[ptr_add(head_q, unsigned'(i))];
            end else begin
                peek[8*i +: 8] = 'x;
            end
        end
    end

    assign count = count_q;

    always_ff @(posedge clk) begin
        if (!reset && !clear && push) begin
            assert (32'(count_q) - 32'(pop) + 32'd2 <= DEPTH);
        end
    end

endmodule

// File: rtl/f8_prefetch_queue.sv
// f8 instruction prefetch: 2-byte fetch per cycle from split even/odd banks into
// a byte queue, exposing up to MAX_INST head bytes and their PC to the decoder.
module f8_prefetch_queue
    import f8_fetch_pkg::*;
#(
    parameter int unsigned DEPTH    = 6,
    parameter int unsigned MAX_INST = 3,
    parameter logic [15:0] RESET_PC = F8_RESET_PC
) (
    input  logic                           clk,
    input  logic                           reset,
    output logic [14:0]                    mem_read_addr_even,
    input  logic [7:0]                     mem_read_data_even,
    output logic [14:0]                    mem_read_addr_odd,
    input  logic [7:0]                     mem_read_data_odd,
    input  logic                           redirect,
    input  logic [15:0]                    redirect_pc,
    input  logic [$clog2(MAX_INST+1)-1:0]  consume,
    output logic [8*MAX_INST-1:0]          inst_bytes,
    output logic [$clog2(MAX_INST+1)-1:0]  inst_avail,
    output logic [15:0]                    inst_pc
);

    localparam int unsigned AW = $clog2(MAX_INST + 1);

    logic [15:0]   fetch_addr_q, fetch_addr_d;
    logic [15:0]   inst_pc_q, inst_pc_d;
    logic          inflight_q, inflight_d;
    logic [15:0]   issue_addr;
    logic          issue;
    int            occupancy;
    bank_addr_t    banks;
    byte_count_t   count;
    logic [AW-1:0] pop;
    logic          push;
    logic [15:0]   push_data;

    always_comb begin
        issue_addr = (redirect && !reset) ? redirect_pc : fetch_addr_q;
        banks      = bank_addr(issue_addr);
        pop        = redirect ? '0 : consume;
        push       = inflight_q && !redirect && !reset;
        // fetch_addr only moves in steps of 2 since the last issue, so its LSB
        // still describes the alignment of the response arriving now.
        push_data  = bank_order(fetch_addr_q, mem_read_data_even, mem_read_data_odd);
        // Bytes held once the pending response lands, plus the 2 a new issue brings.
        occupancy  = int'(count) - int'(pop) + 2 * int'(inflight_q) + 2;
        issue      = !reset && (redirect || occupancy <= int'(DEPTH));
    end

    always_comb begin
        fetch_addr_d = fetch_addr_q;
        inst_pc_d    = inst_pc_q;
        inflight_d   = issue;
        if (redirect) begin
            fetch_addr_d = redirect_pc + 16'd2;
            inst_pc_d    = redirect_pc;
        end else begin
            if (issue) begin
                fetch_addr_d = fetch_addr_q + 16'd2;
            end
            inst_pc_d = inst_pc_q + 16'(consume);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_addr_q <= RESET_PC;
            inst_pc_q    <= RESET_PC;
            inflight_q   <= 1'b0;
        end else begin
            fetch_addr_q <= fetch_addr_d;
            inst_pc_q    <= inst_pc_d;
            inflight_q   <= inflight_d;
        end
    end

    f8_byte_fifo #(
        .DEPTH    (DEPTH),
        .MAX_INST (MAX_INST)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (redirect),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .peek      (inst_bytes),
        .count     (count)
    );

    assign mem_read_addr_even = banks.even;
    assign mem_read_addr_odd  = banks.odd;
    assign inst_pc            = inst_pc_q;
    assign inst_avail = (int'(count) > int'(MAX_INST)) ? AW'(MAX_INST) : AW'(count);

    always_ff @(posedge clk) begin
        if (!reset && !redirect) begin
            assert (consume <= inst_avail);
        end
    end

endmodule
